// File: rtl/ddcpu_worker.sv
// ddcpu_worker -- execution unit of the dataflow CPU.
//
// Takes one fired packet {opcode, insn, d1, d2, d3, d4, dest_option,
// dest_addr, color}, evaluates the instruction and emits one or two result
// tokens {dest_option, dest_addr, color, data} toward the matching/routing
// stage. Only one packet is in flight at a time.
//
// Ports
//   CLK               clock, all state on rising edge
//   RST               asynchronous active-low reset
//   RECEIVE_PC_VALID  input packet valid
//   RECEIVE_PC_READY  worker can accept a packet (IDLE only)
//   RECEIVE_PC_DATA   packet, MSB first
//   SEND_WR_VALID     result valid
//   SEND_WR_READY     downstream accepts result
//   SEND_WR_DATA      result token, MSB first
module ddcpu_worker #(
    parameter int DATA_W              = 32,
    parameter int ADDR_W              = 16,
    parameter int COLOR_W             = 16,
    parameter int OPT_W               = 3,
    parameter int OPCODE_W            = 4,
    parameter int INSN_W              = 8,
    parameter int PACKET_WIDTH        = OPCODE_W + INSN_W + 4*DATA_W + OPT_W + ADDR_W + COLOR_W,
    parameter int WORKER_RESULT_WIDTH = OPT_W + ADDR_W + COLOR_W + DATA_W,
    parameter int OPCODE_EI           = 1,
    parameter int INSN_DISTRIBUTE     = 0,
    parameter int INSN_SWITCH         = 1,
    parameter int INSN_SET_COLOR      = 2,
    parameter int INSN_SYNC           = 3,
    parameter int INSN_PLUS           = 4,
    parameter int INSN_AND            = 5,
    parameter int INSN_NZ             = 6
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           RECEIVE_PC_VALID,
    output logic                           RECEIVE_PC_READY,
    input  logic [PACKET_WIDTH-1:0]        RECEIVE_PC_DATA,
    output logic                           SEND_WR_VALID,
    input  logic                           SEND_WR_READY,
    output logic [WORKER_RESULT_WIDTH-1:0] SEND_WR_DATA
);

    localparam int DEST_W    = OPT_W + ADDR_W;
    localparam int COLOR_LSB = 0;
    localparam int ADDR_LSB  = COLOR_LSB + COLOR_W;
    localparam int OPT_LSB   = ADDR_LSB + ADDR_W;
    localparam int D4_LSB    = OPT_LSB + OPT_W;
    localparam int D3_LSB    = D4_LSB + DATA_W;
    localparam int D2_LSB    = D3_LSB + DATA_W;
    localparam int D1_LSB    = D2_LSB + DATA_W;
    localparam int INSN_LSB  = D1_LSB + DATA_W;
    localparam int OPC_LSB   = INSN_LSB + INSN_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT1,
        S_EMIT2,
        S_DROP
    } state_t;

    state_t state, state_nx;
    logic   live;      // low until the first clock after reset release
    logic   two_res;
    logic [WORKER_RESULT_WIDTH-1:0] r1_q, r2_q;

    // Packet fields
    logic [OPCODE_W-1:0] opcode;
    logic [INSN_W-1:0]   insn;
    logic [DATA_W-1:0]   d1, d2, d3, d4;
    logic [DEST_W-1:0]   pkt_dest, dest2, dest3, dest4;
    logic [COLOR_W-1:0]  color;

    assign opcode   = RECEIVE_PC_DATA[OPC_LSB  +: OPCODE_W];
    assign insn     = RECEIVE_PC_DATA[INSN_LSB +: INSN_W];
    assign d1       = RECEIVE_PC_DATA[D1_LSB   +: DATA_W];
    assign d2       = RECEIVE_PC_DATA[D2_LSB   +: DATA_W];
    assign d3       = RECEIVE_PC_DATA[D3_LSB   +: DATA_W];
    assign d4       = RECEIVE_PC_DATA[D4_LSB   +: DATA_W];
    assign pkt_dest = RECEIVE_PC_DATA[ADDR_LSB +: DEST_W];
    assign color    = RECEIVE_PC_DATA[COLOR_LSB +: COLOR_W];

    // Embedded destinations live in the low bits of an operand; the rest is ignored.
    assign dest2 = d2[DEST_W-1:0];
    assign dest3 = d3[DEST_W-1:0];
    assign dest4 = d4[DEST_W-1:0];

    logic unused_hi;
    assign unused_hi = ^{d3[DATA_W-1:DEST_W], d4[DATA_W-1:DEST_W]};

    // Result evaluation from the incoming packet; latched on accept.
    logic [1:0]                     n_res;
    logic [WORKER_RESULT_WIDTH-1:0] res1, res2;

    always_comb begin
        n_res = 2'd0;
        res1  = '0;
        res2  = '0;
        if (opcode == OPCODE_W'(OPCODE_EI)) begin
            case (insn)
                INSN_W'(INSN_DISTRIBUTE): begin
                    n_res = 2'd2;
                    res1  = {dest2, color, d1};
                    res2  = {dest3, color, d1};
                end
                INSN_W'(INSN_SWITCH): begin
                    n_res = 2'd1;
                    res1  = {(d2 != '0) ? dest3 : dest4, color, d1};
                end
                INSN_W'(INSN_SET_COLOR): begin
                    n_res = 2'd1;
                    res1  = {pkt_dest, d2[COLOR_W-1:0], d1};
                end
                INSN_W'(INSN_SYNC): begin
                    n_res = 2'd2;
                    res1  = {dest3, color, d1};
                    res2  = {dest4, color, d2};
                end
                INSN_W'(INSN_PLUS): begin
                    n_res = 2'd1;
                    res1  = {pkt_dest, color, d1 + d2};
                end
                INSN_W'(INSN_AND): begin
                    n_res = 2'd1;
                    res1  = {pkt_dest, color, d1 & d2};
                end
                INSN_W'(INSN_NZ): begin
                    n_res = 2'd1;
                    res1  = {pkt_dest, color, DATA_W'(d1 != '0)};
                end
                default: n_res = 2'd0;
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            live    <= 1'b0;
            two_res <= 1'b0;
            r1_q    <= '0;
            r2_q    <= '0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (RECEIVE_PC_VALID && RECEIVE_PC_READY) begin
                two_res <= (n_res == 2'd2);
                r1_q    <= res1;
                r2_q    <= res2;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:
                if (RECEIVE_PC_VALID && RECEIVE_PC_READY)
                    state_nx = (n_res == 2'd0) ? S_DROP : S_EMIT1;
            S_EMIT1:
                if (SEND_WR_READY)
                    state_nx = two_res ? S_EMIT2 : S_IDLE;
            S_EMIT2:
                if (SEND_WR_READY)
                    state_nx = S_IDLE;
            S_DROP:
                state_nx = S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        RECEIVE_PC_READY = 1'b0;
        SEND_WR_VALID    = 1'b0;
        SEND_WR_DATA     = '0;
        case (state)
            S_IDLE:  RECEIVE_PC_READY = live;
            S_EMIT1: begin
                SEND_WR_VALID = 1'b1;
                SEND_WR_DATA  = r1_q;
            end
            S_EMIT2: begin
                SEND_WR_VALID = 1'b1;
                SEND_WR_DATA  = r2_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ddcpu_worker.sv
module tb_ddcpu_worker;

    localparam int PW = 175;
    localparam int RW = 67;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RECEIVE_PC_VALID = 1'b0;
    logic          RECEIVE_PC_READY;
    logic [PW-1:0] RECEIVE_PC_DATA = '0;
    logic          SEND_WR_VALID;
    logic          SEND_WR_READY = 1'b0;
    logic [RW-1:0] SEND_WR_DATA;

    ddcpu_worker dut (
        .CLK              (CLK),
        .RST              (RST),
        .RECEIVE_PC_VALID (RECEIVE_PC_VALID),
        .RECEIVE_PC_READY (RECEIVE_PC_READY),
        .RECEIVE_PC_DATA  (RECEIVE_PC_DATA),
        .SEND_WR_VALID    (SEND_WR_VALID),
        .SEND_WR_READY    (SEND_WR_READY),
        .SEND_WR_DATA     (SEND_WR_DATA)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit started = 0;
    logic [RW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [3:0] op, input logic [7:0] insn,
                                         input logic [31:0] d1, input logic [31:0] d2,
                                         input logic [31:0] d3, input logic [31:0] d4,
                                         input logic [2:0] opt, input logic [15:0] addr,
                                         input logic [15:0] color);
        return {op, insn, d1, d2, d3, d4, opt, addr, color};
    endfunction

    // Reference model: results a packet should produce, straight from the instruction rules.
    function automatic void model(input logic [PW-1:0] p, output int n,
                                  output logic [RW-1:0] e1, output logic [RW-1:0] e2);
        logic [3:0]  op;
        logic [7:0]  insn;
        logic [31:0] d1, d2, d3, d4, sel;
        logic [18:0] pdest;
        logic [15:0] col;
        {op, insn, d1, d2, d3, d4, pdest, col} = p;
        n = 0; e1 = '0; e2 = '0;
        if (op != 4'd1) return;
        case (insn)
            8'd0: begin n = 2; e1 = {d2[18:0], col, d1}; e2 = {d3[18:0], col, d1}; end
            8'd1: begin
                sel = (d2 != 0) ? d3 : d4;
                n = 1; e1 = {sel[18:0], col, d1};
            end
            8'd2: begin n = 1; e1 = {pdest, d2[15:0], d1}; end
            8'd3: begin n = 2; e1 = {d3[18:0], col, d1}; e2 = {d4[18:0], col, d2}; end
            8'd4: begin n = 1; e1 = {pdest, col, 32'(d1 + d2)}; end
            8'd5: begin n = 1; e1 = {pdest, col, d1 & d2}; end
            8'd6: begin n = 1; e1 = {pdest, col, (d1 != 0) ? 32'd1 : 32'd0}; end
            default: n = 0;
        endcase
    endfunction

    // Present one packet; expectations are queued before the handshake.
    task automatic send(input logic [PW-1:0] p, input int n,
                        input logic [RW-1:0] e1, input logic [RW-1:0] e2);
        int waitc = 0;
        @(negedge CLK);
        while (!RECEIVE_PC_READY && waitc < 300) begin
            @(negedge CLK);
            waitc++;
        end
        if (!RECEIVE_PC_READY) begin
            chk("ready_timeout", RW'(RECEIVE_PC_READY), RW'(1));
            return;
        end
        if (n >= 1) exp_q.push_back(e1);
        if (n >= 2) exp_q.push_back(e2);
        RECEIVE_PC_VALID = 1'b1;
        RECEIVE_PC_DATA  = p;
        @(negedge CLK);
        RECEIVE_PC_VALID = 1'b0;
        RECEIVE_PC_DATA  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send_model(input logic [PW-1:0] p);
        int n;
        logic [RW-1:0] e1, e2;
        model(p, n, e1, e2);
        send(p, n, e1, e2);
    endtask

    task automatic directed();
        logic [15:0] ra = 16'($urandom);
        send(mk(4'd1, 8'd0, 32'hDEADBEEF, 32'h0002DEAD, 32'h0005BEEF, 32'($urandom), 3'd6, ra, 16'h0F0F),
             2, {3'b010, 16'hDEAD, 16'h0F0F, 32'hDEADBEEF}, {3'b101, 16'hBEEF, 16'h0F0F, 32'hDEADBEEF});
        send(mk(4'd1, 8'd1, 32'h1234ABCD, 32'd1, 32'h00000F0F, 32'h0007F0F0, 3'd2, ra, 16'hABCD),
             1, {3'b000, 16'h0F0F, 16'hABCD, 32'h1234ABCD}, '0);
        send(mk(4'd1, 8'd1, 32'h1234ABCD, 32'd0, 32'h00000F0F, 32'h0007F0F0, 3'd2, ra, 16'hABCD),
             1, {3'b111, 16'hF0F0, 16'hABCD, 32'h1234ABCD}, '0);
        send(mk(4'd1, 8'd2, 32'hABCD1234, 32'h0000BADC, 32'($urandom), 32'($urandom), 3'b001, 16'h0A0A, 16'hABCD),
             1, {3'b001, 16'h0A0A, 16'hBADC, 32'hABCD1234}, '0);
        send(mk(4'd1, 8'd3, 32'hDEADBEEF, 32'h43215678, 32'h00048776, 32'h00032030, 3'd0, ra, 16'h1111),
             2, {3'b100, 16'h8776, 16'h1111, 32'hDEADBEEF}, {3'b011, 16'h2030, 16'h1111, 32'h43215678});
        send(mk(4'd1, 8'd4, 32'hDEAD0000, 32'h0000BEEF, 32'($urandom), 32'($urandom), 3'b101, 16'h1234, 16'h2222),
             1, {3'b101, 16'h1234, 16'h2222, 32'hDEADBEEF}, '0);
        send(mk(4'd1, 8'd4, 32'hFFFFFFFF, 32'h00000002, 32'd0, 32'd0, 3'b001, 16'h0001, 16'h2222),
             1, {3'b001, 16'h0001, 16'h2222, 32'h00000001}, '0);
        send(mk(4'd1, 8'd5, 32'hDEADDEAD, 32'hBEEFBEEF, 32'd0, 32'd0, 3'b110, 16'h5555, 16'h3333),
             1, {3'b110, 16'h5555, 16'h3333, 32'h9EAD9EAD}, '0);
        send(mk(4'd1, 8'd6, 32'h00100000, 32'($urandom), 32'd0, 32'd0, 3'b011, 16'h7777, 16'h4444),
             1, {3'b011, 16'h7777, 16'h4444, 32'h00000001}, '0);
        send(mk(4'd1, 8'd6, 32'h00000000, 32'($urandom), 32'd0, 32'd0, 3'b011, 16'h7777, 16'h4444),
             1, {3'b011, 16'h7777, 16'h4444, 32'h00000000}, '0);
        // No result expected: wrong opcode, then unknown instruction.
        send(mk(4'd2, 8'd4, 32'h1, 32'h2, 32'h3, 32'h4, 3'd1, 16'h1, 16'h1), 0, '0, '0);
        send(mk(4'd1, 8'd9, 32'h1, 32'h2, 32'h3, 32'h4, 3'd1, 16'h1, 16'h1), 0, '0, '0);
    endtask

    // Downstream side: random backpressure with occasional long stalls; checks
    // every presented result against the scoreboard and the hold-stable rule.
    initial begin
        int hold_cnt = 0;
        bit held_v = 0;
        logic [RW-1:0] held = '0;
        logic [RW-1:0] e;
        forever begin
            @(negedge CLK);
            if (started) begin
                if (hold_cnt > 0) begin
                    SEND_WR_READY = 1'b0;
                    hold_cnt--;
                end else if ($urandom_range(0, 19) == 0) begin
                    hold_cnt = $urandom_range(3, 8);
                    SEND_WR_READY = 1'b0;
                end else begin
                    SEND_WR_READY = ($urandom_range(0, 3) != 0);
                end
                #1;
                if (held_v) begin
                    chk("hold_valid", RW'(SEND_WR_VALID), RW'(1));
                    chk("hold_data", SEND_WR_DATA, held);
                end
                if (SEND_WR_VALID) begin
                    chk("busy_not_ready", RW'(RECEIVE_PC_READY), RW'(0));
                    if (SEND_WR_READY) begin
                        held_v = 0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", SEND_WR_DATA, RW'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk("result", SEND_WR_DATA, e);
                        end
                    end else begin
                        held_v = 1;
                        held   = SEND_WR_DATA;
                    end
                end else begin
                    held_v = 0;
                end
            end
        end
    end

    initial begin
        int drain;
        logic [3:0] op;
        logic [7:0] insn;
        logic [31:0] d1, d2;

        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_ready", RW'(RECEIVE_PC_READY), RW'(0));
        chk("reset_valid", RW'(SEND_WR_VALID), RW'(0));
        chk("reset_data", SEND_WR_DATA, RW'(0));
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("post_reset_ready", RW'(RECEIVE_PC_READY), RW'(1));
        chk("post_reset_valid", RW'(SEND_WR_VALID), RW'(0));
        started = 1;

        for (int unsigned k = 0; k < 10; k++) directed();

        for (int unsigned k = 0; k < 300; k++) begin
            op   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd1;
            insn = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            d1   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            d2   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            send_model(mk(op, insn, d1, d2, $urandom, $urandom, 3'($urandom), 16'($urandom), 16'($urandom)));
        end

        drain = 0;
        while (exp_q.size() != 0 && drain < 5000) begin
            @(negedge CLK);
            drain++;
        end
        chk("drain_empty", RW'(exp_q.size()), RW'(0));
        repeat (20) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
